// File: rtl/alu_result_stage.sv
// Registered result stage behind the add/subtract unit. Derives the NZCV flags,
// buffers results in a 2-entry skid buffer and keeps overflow statistics.
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_of,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_flags,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_stats
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] skid_data;
  logic [3:0]       skid_flags;
  logic [3:0]       cap_flags;
  logic             accept;
  logic             present;

  assign accept  = in_valid & in_ready;
  assign present = out_valid & out_ready;

  // A subtract runs the adder with cin=1, so the borrow is the inverted carry-out.
  always_comb begin
    cap_flags = {in_sum[WIDTH-1], (in_sum == '0), (in_sub ? ~in_cout : in_cout), in_of};
  end

  // The main register drives the outputs directly; skid only fills under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      out_data   <= '0;
      out_flags  <= '0;
      skid_data  <= '0;
      skid_flags <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= in_sum;
            out_flags <= cap_flags;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && present) begin
            out_data  <= in_sum;
            out_flags <= cap_flags;
          end else if (accept) begin
            skid_data  <= in_sum;
            skid_flags <= cap_flags;
            in_ready   <= 1'b0;
            state      <= TWO;
          end else if (present) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (present) begin
            out_data  <= skid_data;
            out_flags <= skid_flags;
            in_ready  <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

  // An accepted overflow outranks a coincident clear, restarting the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (accept && in_of) begin
      ovf_sticky <= 1'b1;
      if (clr_stats) begin
        ovf_count <= CNT_ONE;
      end else if (ovf_count != CNT_MAX) begin
        ovf_count <= ovf_count + CNT_ONE;
      end
    end else if (clr_stats) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic
// compared against a queue-based model of a 2-deep FIFO with overflow statistics.
module tb_alu_result_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sum;
  logic       in_cout;
  logic       in_of;
  logic       in_sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_flags;
  logic       ovf_sticky;
  logic [3:0] ovf_count;
  logic       clr_stats;

  int checks;
  int failures;

  logic [11:0] mq[$];
  logic [7:0]  last_data;
  logic [3:0]  last_flags;
  logic        m_sticky;
  int          m_count;

  alu_result_stage #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .in_of(in_of), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count),
    .clr_stats(clr_stats)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [3:0] flags_of(input logic [7:0] s, input logic co,
                                          input logic o, input logic sb);
    return {s[7], (s == 8'h00), (sb ? ~co : co), o};
  endfunction

  function automatic logic [7:0] exp_data();
    logic [11:0] e;
    if (mq.size() > 0) begin
      e = mq[0];
      return e[11:4];
    end
    return last_data;
  endfunction

  function automatic logic [3:0] exp_flags();
    logic [11:0] e;
    if (mq.size() > 0) begin
      e = mq[0];
      return e[3:0];
    end
    return last_flags;
  endfunction

  task automatic model_reset();
    mq.delete();
    last_data  = 8'h00;
    last_flags = 4'h0;
    m_sticky   = 1'b0;
    m_count    = 0;
  endtask

  // Drive one cycle of inputs, then advance the model on the same rising edge.
  task automatic tick(input logic iv, input logic [7:0] s, input logic co, input logic o,
                      input logic sb, input logic ordy, input logic clr);
    logic        acc;
    logic        pres;
    logic [11:0] popped;
    @(negedge clk);
    in_valid  = iv;
    in_sum    = s;
    in_cout   = co;
    in_of     = o;
    in_sub    = sb;
    out_ready = ordy;
    clr_stats = clr;
    @(posedge clk);
    acc  = iv && (mq.size() < 2);
    pres = (mq.size() > 0) && ordy;
    if (pres) begin
      popped     = mq.pop_front();
      last_data  = popped[11:4];
      last_flags = popped[3:0];
    end
    if (acc) mq.push_back({s, flags_of(s, co, o, sb)});
    if (acc && o) begin
      m_sticky = 1'b1;
      m_count  = clr ? 1 : ((m_count < 15) ? m_count + 1 : 15);
    end else if (clr) begin
      m_sticky = 1'b0;
      m_count  = 0;
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (out_flags !== 4'h0) begin failures++; $display("[TB] FAIL reset_out_flags got %b want 0000", out_flags); end
    checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("[TB] FAIL reset_sticky got %b want 0", ovf_sticky); end
    checks++; if (ovf_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got %0d want 0", ovf_count); end
    tick(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL pre_reset_full got in_ready=%b want 0", in_ready); end
    checks++; if (ovf_count !== 4'd1) begin failures++; $display("[TB] FAIL pre_reset_count got %0d want 1", ovf_count); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL async_reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("[TB] FAIL async_reset_out_data got %h want 00", out_data); end
    checks++; if (ovf_count !== 4'd0) begin failures++; $display("[TB] FAIL async_reset_count got %0d want 0", ovf_count); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_flags();
    tick(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("[TB] FAIL add_data got %h want 00", out_data); end
    checks++; if (out_flags !== 4'b0110) begin failures++; $display("[TB] FAIL add_flags got %b want 0110", out_flags); end
    drain();
  endtask

  task automatic test_sub_overflow();
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (out_data !== 8'h80) begin failures++; $display("[TB] FAIL sub_data got %h want 80", out_data); end
    checks++; if (out_flags !== 4'b1011) begin failures++; $display("[TB] FAIL sub_flags got %b want 1011", out_flags); end
    checks++; if (ovf_sticky !== 1'b1) begin failures++; $display("[TB] FAIL sub_sticky got %b want 1", ovf_sticky); end
    checks++; if (ovf_count !== 4'd1) begin failures++; $display("[TB] FAIL sub_count got %0d want 1", ovf_count); end
    drain();
  endtask

  task automatic test_backpressure();
    tick(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_full_ready got %b want 0", in_ready); end
    tick(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (out_data !== 8'h11) begin failures++; $display("[TB] FAIL bp_head got %h want 11", out_data); end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (out_data !== 8'h22 || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_second got %h/%b want 22/1", out_data, out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_back got %b want 1", in_ready); end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h22) begin failures++; $display("[TB] FAIL bp_drained got %h/%b want 22/0 (33 dropped)", out_data, out_valid); end
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(k) || in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stream_%0d got data=%h valid=%b ready=%b want %h/1/1", k, out_data, out_valid, in_ready, 8'(k));
      end
    end
    drain();
  endtask

  task automatic test_saturation();
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 17; k++) tick(1'b1, 8'(k + 3), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (ovf_count !== 4'd15) begin failures++; $display("[TB] FAIL sat_count got %0d want 15", ovf_count); end
    tick(1'b0, 8'h7f, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (ovf_count !== 4'd15 || ovf_sticky !== 1'b1) begin failures++; $display("[TB] FAIL sat_hold got %0d/%b want 15/1", ovf_count, ovf_sticky); end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (ovf_count !== 4'd0 || ovf_sticky !== 1'b0) begin failures++; $display("[TB] FAIL clr_stats got %0d/%b want 0/0", ovf_count, ovf_sticky); end
    tick(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++; if (ovf_count !== 4'd1 || ovf_sticky !== 1'b1) begin failures++; $display("[TB] FAIL clr_vs_ovf got %0d/%b want 1/1", ovf_count, ovf_sticky); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      checks++; if (out_valid !== (mq.size() > 0)) begin failures++; $display("[TB] FAIL rnd_valid cyc %0d got %b want %b", i, out_valid, mq.size() > 0); end
      checks++; if (in_ready !== (mq.size() < 2)) begin failures++; $display("[TB] FAIL rnd_ready cyc %0d got %b want %b", i, in_ready, mq.size() < 2); end
      checks++; if (out_data !== exp_data()) begin failures++; $display("[TB] FAIL rnd_data cyc %0d got %h want %h", i, out_data, exp_data()); end
      checks++; if (out_flags !== exp_flags()) begin failures++; $display("[TB] FAIL rnd_flags cyc %0d got %b want %b", i, out_flags, exp_flags()); end
      checks++; if (ovf_sticky !== m_sticky) begin failures++; $display("[TB] FAIL rnd_sticky cyc %0d got %b want %b", i, ovf_sticky, m_sticky); end
      checks++; if (ovf_count !== 4'(m_count)) begin failures++; $display("[TB] FAIL rnd_count cyc %0d got %0d want %0d", i, ovf_count, m_count); end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = 8'h00;
    in_cout   = 1'b0;
    in_of     = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_add_flags();
    test_sub_overflow();
    test_backpressure();
    test_streaming();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered result stage directly downstream of the 8-bit ripple-carry add/subtract unit. It captures the adder's sum, carry-out and overflow with the operation type, and derives status flags Z, N, C/borrow and V. It presents the result through a 2-entry skid buffer with valid/ready handshake, and keeps a sticky overflow flag plus a saturating overflow-event counter for the ALU control block.

Parameters:
WIDTH, 8, data width of sum and out_data
CNT_W, 4, width of overflow event counter (saturates at 2^CNT_W-1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  adder result presented this cycle
in_ready  output  1  stage can accept a result this cycle
in_sum  input  WIDTH  adder sum
in_cout  input  1  adder carry-out
in_of  input  1  adder signed overflow
in_sub  input  1  1 = operation was subtract (adder cin=1)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  registered sum
out_flags  output  4  {N,Z,C,V}
ovf_sticky  output  1  set by any accepted result with V=1
ovf_count  output  CNT_W  count of accepted results with V=1, saturating
clr_stats  input  1  synchronous clear of ovf_sticky and ovf_count

Behaviour:
- Reset (async, rst=1): both buffer entries empty; out_valid=0, in_ready=1, out_data=0, out_flags=0, ovf_sticky=0, ovf_count=0. Release is synchronous to clk.
- Flag derivation at capture: N=in_sum[WIDTH-1]; Z=(in_sum==0); V=in_of; C=in_cout when in_sub=0, C=~in_cout (borrow) when in_sub=1.
- Accept: in_valid & in_ready at rising edge. Present: out_valid & out_ready at rising edge.
- Buffer: main register (drives outputs) + skid register. States: EMPTY (0 entries), ONE (main full), TWO (main + skid full).
  - EMPTY: accept -> ONE; data into main; out_valid next cycle (1-cycle latency).
  - ONE: accept only -> TWO (into skid); present only -> EMPTY; accept+present same edge -> ONE, new data into main.
  - TWO: in_ready=0; present -> ONE, skid moves to main; in_valid ignored.
- in_ready is registered: 1 in EMPTY and ONE, 0 in TWO. No combinational path from out_ready to in_ready.
- Order strictly FIFO; no result dropped or duplicated.
- out_data/out_flags hold their last value when out_valid=0. They change only when main is loaded.
- Stats update on accept, not present. On an accepted result with V=1: ovf_sticky<=1 and ovf_count<=ovf_count+1, held at all-ones (no wrap).
- clr_stats=1 clears both stats. If clr_stats and an accepted V=1 result coincide, the result wins: sticky=1, count=1.
- rst asserted mid-transfer discards both entries immediately (async); no partial handshake survives.
- Data on in_* ignored when in_valid=0 or in_ready=0.

Test Plan:
- Reset: assert rst mid-cycle with TWO entries -> out_valid=0, in_ready=1, out_data=0, ovf_count=0 immediately, without waiting for a clock edge.
- Add flags: in_sum=0x00, cout=1, of=0, sub=0, out_ready=1 -> next cycle out_valid=1, out_data=0x00, flags N=0 Z=1 C=1 V=0.
- Subtract borrow/overflow: in_sum=0x80, cout=0, of=1, sub=1 -> flags N=1 Z=0 C=1 V=1; ovf_sticky=1, ovf_count=1.
- Backpressure: out_ready=0, push 0x11, 0x22, 0x33 on consecutive cycles -> 0x11, 0x22 accepted, in_ready=0 on third, 0x33 not accepted. Raise out_ready -> 0x11 then 0x22 in order.
- Streaming: out_ready=1, in_valid=1 for 10 cycles with sums 1..10 -> in_ready stays 1, outputs 1..10 one per cycle, 1-cycle latency.
- Counter saturation/clear: 17 accepted V=1 results (CNT_W=4) -> ovf_count=15. clr_stats -> 0, sticky=0. clr_stats coincident with accepted V=1 result -> count=1, sticky=1.
